// File: rtl/uart_rx_pkt_ctrl_if.sv
// Host read port of the UART packet controller: packet-valid/length status,
// release acknowledge, and the registered payload read path.
interface uart_rx_pkt_ctrl_if #(
  parameter int unsigned AW = 5
);
  logic          pkt_valid_out;
  logic [AW-1:0] pkt_len_out;
  logic          pkt_ack_in;
  logic [AW-1:0] rd_addr_in;
  logic [7:0]    rd_data_out;

  // master: the packet controller; slave: the host consuming packets
  modport master (
    output pkt_valid_out, pkt_len_out, rd_data_out,
    input  pkt_ack_in, rd_addr_in
  );
  modport slave (
    input  pkt_valid_out, pkt_len_out, rd_data_out,
    output pkt_ack_in, rd_addr_in
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames uart_rx bytes as SOF/LEN/payload/CHK, validates length and XOR checksum,
// enforces an inter-byte timeout and holds each good packet until the host acks it.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 17360,
  parameter int unsigned AW             = $clog2(MAX_LEN + 1)
) (
  input  logic                sysclk_in,
  input  logic                nrst_in,
  input  logic [7:0]          rx_data_in,
  input  logic                data_rdy_in,
  uart_rx_pkt_ctrl_if.master  host,
  output logic                err_crc_out,
  output logic                err_len_out,
  output logic                err_timeout_out,
  output logic                err_overrun_out,
  output logic [2:0]          state_dbg_out
);

  localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  state_e          state_q;
  logic            rdy_q;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   idx_d;
  logic [AW-1:0]   plen_q;
  logic            valid_q;
  logic [7:0]      chk_q;
  logic [7:0]      rd_data_q;
  logic [TW-1:0]   cnt_q;
  logic [TW-1:0]   cnt_d;
  logic            err_crc_q;
  logic            err_len_q;
  logic            err_timeout_q;
  logic            err_overrun_q;
  logic [7:0]      pbuf_q [DEPTH];

  logic            byte_evt_c;
  logic            counting_c;
  logic            tmo_hit_c;

  assign byte_evt_c = data_rdy_in & ~rdy_q;
  assign counting_c = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign tmo_hit_c  = (cnt_q == TW'(TIMEOUT_CYCLES - 2));
  assign idx_d      = idx_q + AW'(1);
  assign cnt_d      = cnt_q + TW'(1);

  // Frame FSM, timeout counter and error pulses
  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q       <= S_IDLE;
      rdy_q         <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      plen_q        <= '0;
      valid_q       <= 1'b0;
      chk_q         <= 8'h00;
      cnt_q         <= '0;
      err_crc_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rdy_q         <= data_rdy_in;
      err_crc_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      cnt_q         <= (byte_evt_c || !counting_c || tmo_hit_c) ? '0 : cnt_d;

      unique case (state_q)
        S_IDLE: begin
          if (byte_evt_c && (rx_data_in == SOF_BYTE)) state_q <= S_LEN;
        end
        S_LEN: begin
          if (byte_evt_c) begin
            len_q <= AW'(rx_data_in);
            chk_q <= rx_data_in;
            idx_q <= '0;
            if (rx_data_in > 8'(MAX_LEN)) begin
              err_len_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (rx_data_in == 8'h00) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_evt_c) begin
            chk_q <= chk_q ^ rx_data_in;
            idx_q <= idx_d;
            if (idx_d == len_q) state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (byte_evt_c) begin
            if (rx_data_in == chk_q) begin
              valid_q <= 1'b1;
              plen_q  <= len_q;
              state_q <= S_HOLD;
            end else begin
              err_crc_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          // Ack wins over a simultaneous byte, which is then treated as in IDLE
          if (host.pkt_ack_in) begin
            valid_q <= 1'b0;
            plen_q  <= '0;
            state_q <= (byte_evt_c && (rx_data_in == SOF_BYTE)) ? S_LEN : S_IDLE;
          end else if (byte_evt_c) begin
            err_overrun_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (counting_c && !byte_evt_c && tmo_hit_c) begin
        err_timeout_q <= 1'b1;
        state_q       <= S_IDLE;
      end
    end
  end

  // Payload buffer; contents survive reset
  always_ff @(posedge sysclk_in) begin
    if ((state_q == S_PAYLOAD) && byte_evt_c) pbuf_q[IW'(idx_q)] <= rx_data_in;
  end

  // Registered host read, zero outside the held payload
  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rd_data_q <= 8'h00;
    end else if (valid_q && (host.rd_addr_in < plen_q)) begin
      rd_data_q <= pbuf_q[IW'(host.rd_addr_in)];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  assign host.pkt_valid_out = valid_q;
  assign host.pkt_len_out   = plen_q;
  assign host.rd_data_out   = rd_data_q;
  assign err_crc_out        = err_crc_q;
  assign err_len_out        = err_len_q;
  assign err_timeout_out    = err_timeout_q;
  assign err_overrun_out    = err_overrun_q;
  assign state_dbg_out      = 3'(state_q);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: stimulus queues expected events and read
// data; a monitor pops and compares whenever the DUT presents an event or read.
module tb_uart_rx_pkt_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 64;
  localparam int unsigned AW      = 5;
  localparam logic [7:0]  SOF     = 8'hA5;

  typedef enum int {EV_PKT, EV_CRC, EV_LEN, EV_TMO, EV_OVR} ev_e;
  typedef struct { ev_e kind; int len; } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rdy = 1'b0;
  logic       rd_stb = 1'b0;
  logic       err_crc, err_len, err_tmo, err_ovr;
  logic [2:0] state_dbg;

  uart_rx_pkt_ctrl_if #(.AW(AW)) hif ();

  uart_rx_pkt_ctrl #(
    .SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .AW(AW)
  ) dut (
    .sysclk_in(clk), .nrst_in(rst_n), .rx_data_in(rx_data), .data_rdy_in(rdy),
    .host(hif.master),
    .err_crc_out(err_crc), .err_len_out(err_len), .err_timeout_out(err_tmo),
    .err_overrun_out(err_ovr), .state_dbg_out(state_dbg)
  );

  always #5 clk = ~clk;

  exp_t       evq [$];
  logic [7:0] rdq [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int evt_cyc = 0;
  logic rdy_prev = 1'b0;
  logic val_prev = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: sample 1 ns after each rising edge
  always @(posedge clk) begin
    int   nerr;
    ev_e  kind;
    exp_t e;
    logic [7:0] er;
    #1;
    cyc++;
    if (rdy && !rdy_prev) evt_cyc = cyc;
    rdy_prev = rdy;
    nerr = int'(err_crc) + int'(err_len) + int'(err_tmo) + int'(err_ovr);
    if (nerr > 1) begin
      n_chk++; n_fail++;
      $display("FAIL err_exclusive: got %0d pulses expected 1", nerr);
    end
    if (nerr == 1 || (hif.pkt_valid_out && !val_prev)) begin
      kind = err_crc ? EV_CRC : err_len ? EV_LEN : err_tmo ? EV_TMO :
             err_ovr ? EV_OVR : EV_PKT;
      n_chk++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d expected none", int'(kind));
      end else begin
        e = evq.pop_front();
        if (e.kind != kind) begin
          n_fail++;
          $display("FAIL event_kind: got %0d expected %0d", int'(kind), int'(e.kind));
        end else if (kind == EV_PKT && int'(hif.pkt_len_out) != e.len) begin
          n_fail++;
          $display("FAIL pkt_len: got %0d expected %0d", hif.pkt_len_out, e.len);
        end else if (kind == EV_TMO && (cyc - evt_cyc) != int'(TMO - 1)) begin
          n_fail++;
          $display("FAIL timeout_latency: got %0d expected %0d", cyc - evt_cyc, TMO - 1);
        end
      end
    end
    val_prev = hif.pkt_valid_out;
    if (rd_stb) begin
      n_chk++;
      if (rdq.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected none", hif.rd_data_out);
      end else begin
        er = rdq.pop_front();
        if (hif.rd_data_out !== er) begin
          n_fail++;
          $display("FAIL rd_data: got %0h expected %0h", hif.rd_data_out, er);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rdy = 1'b1;
    @(negedge clk); @(negedge clk); rdy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    @(negedge clk); hif.rd_addr_in = AW'(a); rd_stb = 1'b1; rdq.push_back(e);
    @(negedge clk); rd_stb = 1'b0;
  endtask

  task automatic ack(input string nm);
    @(negedge clk); hif.pkt_ack_in = 1'b1;
    @(negedge clk); hif.pkt_ack_in = 1'b0;
    check({nm, "_valid_after_ack"}, int'(hif.pkt_valid_out), 0);
    check({nm, "_state_after_ack"}, int'(state_dbg), 0);
  endtask

  task automatic push_ev(input ev_e k, input int l);
    exp_t e;
    e.kind = k; e.len = l;
    evq.push_back(e);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_state"}, int'(state_dbg), 0);
    check({nm, "_valid"}, int'(hif.pkt_valid_out), 0);
    check({nm, "_len"}, int'(hif.pkt_len_out), 0);
    check({nm, "_rd_data"}, int'(hif.rd_data_out), 0);
    check({nm, "_errs"}, int'({err_crc, err_len, err_tmo, err_ovr}), 0);
  endtask

  task automatic good_pkt1(input string nm);
    push_ev(EV_PKT, 3);
    send_seq(64'hA5_03_11_22_33_03, 6);
    check({nm, "_valid"}, int'(hif.pkt_valid_out), 1);
    check({nm, "_state"}, int'(state_dbg), 4);
    rd(0, 8'h11); rd(1, 8'h22); rd(2, 8'h33); rd(3, 8'h00);
    ack(nm);
  endtask

  initial begin
    hif.pkt_ack_in = 1'b0;
    hif.rd_addr_in = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    good_pkt1("t1");
    rd(0, 8'h00);

    push_ev(EV_CRC, 0);
    send_seq(64'hA5_03_11_22_33_04, 6);
    check("t2_valid", int'(hif.pkt_valid_out), 0);
    check("t2_state", int'(state_dbg), 0);

    push_ev(EV_LEN, 0);
    send_seq(64'hA5_11, 2);
    check("t3_state_after_len", int'(state_dbg), 0);
    push_ev(EV_PKT, 1);
    send_seq(64'hA5_01_5A_5B, 4);
    rd(0, 8'h5A);
    ack("t3");

    push_ev(EV_TMO, 0);
    send_seq(64'hA5_02_11, 3);
    repeat (TMO + 10) @(negedge clk);
    check("t4_state_after_tmo", int'(state_dbg), 0);
    good_pkt1("t4b");

    push_ev(EV_PKT, 0);
    send_seq(64'h00_FF_A5_00_00, 5);
    check("t5_valid", int'(hif.pkt_valid_out), 1);
    rd(0, 8'h00);
    push_ev(EV_OVR, 0);
    send_byte(8'h77);
    check("t5_valid_after_ovr", int'(hif.pkt_valid_out), 1);
    check("t5_state_after_ovr", int'(state_dbg), 4);
    rd(0, 8'h00);

    // Ack and SOF on the same edge: ack wins, SOF starts a new frame
    @(negedge clk); rx_data = SOF; rdy = 1'b1; hif.pkt_ack_in = 1'b1;
    @(negedge clk); hif.pkt_ack_in = 1'b0;
    @(negedge clk); rdy = 1'b0;
    check("t5b_valid", int'(hif.pkt_valid_out), 0);
    check("t5b_state_len", int'(state_dbg), 1);
    repeat (3) @(negedge clk);
    push_ev(EV_PKT, 1);
    send_seq(64'h01_5A_5B, 3);
    push_ev(EV_OVR, 0);
    send_byte(8'h77);
    rd(0, 8'h5A);
    ack("t5b");

    send_seq(64'hA5_04_11, 3);
    check("t6_state_mid", int'(state_dbg), 2);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_reset");
    rst_n = 1'b1;
    repeat (TMO + 5) @(negedge clk);
    good_pkt1("t6b");

    repeat (4) @(negedge clk);
    check("evq_drained", evq.size(), 0);
    check("rdq_drained", rdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
